// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
//   Shared types for the systolic array datapath.
//   MAC_DATA_W      : width of one MAC operand element
//   t_mac_data      : signed MAC operand element
//   t_feeder_state  : row-feeder control states
// ---------------------------------------------------------------------------
package systolic_pkg;

    localparam int unsigned MAC_DATA_W = 8;

    typedef logic signed [MAC_DATA_W-1:0] t_mac_data;

    typedef enum logic [1:0] {
        FEEDER_IDLE,
        FEEDER_STREAM,
        FEEDER_FLUSH
    } t_feeder_state;

endpackage

// File: rtl/feeder_fifo.sv
// ---------------------------------------------------------------------------
// feeder_fifo
//   Synchronous FIFO with show-ahead read data (head entry always visible).
//   clock_i   in   clock
//   resetn_i  in   asynchronous active-low reset
//   push_i    in   write wdata_i (ignored when full)
//   pop_i     in   drop head entry (ignored when empty)
//   wdata_i   in   entry to write
//   rdata_o   out  head entry
//   full_o    out  count == DEPTH
//   empty_o   out  count == 0
//   count_o   out  number of stored entries
// ---------------------------------------------------------------------------
module feeder_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock_i,
    input  logic                   resetn_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from the registered count only, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rd_ptr];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wdata_i;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/systolic_row_feeder.sv
// ---------------------------------------------------------------------------
// systolic_row_feeder
//   Buffers row-vectors in a FIFO and streams one per cycle into the array's
//   per-row skew registers; after a tile's last vector it issues
//   FLUSH_CYCLES zero vectors so the skew chains and PEs drain.
//   clock_i      in   system clock
//   resetn_i     in   asynchronous active-low reset
//   s_data_i     in   input vector, element r for array row r
//   s_valid_i    in   input vector valid
//   s_last_i     in   last vector of tile (qualified by s_valid_i)
//   s_ready_o    out  FIFO not full
//   stall_i      in   array stall, freezes the output side
//   data_o       out  vector to the skew registers
//   valid_o      out  data_o is a real tile vector
//   flush_o      out  data_o is a drain zero vector
//   tile_done_o  out  pulse when the final flush vector is issued
//   busy_o       out  not idle or FIFO non-empty
// ---------------------------------------------------------------------------
module systolic_row_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS         = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned FLUSH_CYCLES = 7
) (
    input  logic      clock_i,
    input  logic      resetn_i,
    input  t_mac_data s_data_i [ROWS],
    input  logic      s_valid_i,
    input  logic      s_last_i,
    output logic      s_ready_o,
    input  logic      stall_i,
    output t_mac_data data_o [ROWS],
    output logic      valid_o,
    output logic      flush_o,
    output logic      tile_done_o,
    output logic      busy_o
);

    localparam int unsigned WORD_W = ROWS * MAC_DATA_W + 1;
    localparam int unsigned CNT_W  = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    t_feeder_state r_state;
    t_feeder_state w_state_nxt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] w_flush_cnt_nxt;
    t_mac_data r_data [ROWS];
    t_mac_data w_data_nxt [ROWS];
    logic r_valid;
    logic w_valid_nxt;
    logic r_flush;
    logic w_flush_nxt;
    logic r_done;
    logic w_done_nxt;

    logic [WORD_W-1:0] w_push_word;
    logic [WORD_W-1:0] w_head_word;
    t_mac_data         w_head_data [ROWS];
    logic              w_head_last;
    logic              w_full;
    logic              w_empty;
    logic [FCNT_W-1:0] w_count;
    logic              w_pop;

    // FIFO word layout: bit 0 = last flag, element r above it.
    always_comb begin
        w_push_word    = '0;
        w_push_word[0] = s_last_i;
        for (int unsigned r = 0; r < ROWS; r++) begin
            w_push_word[r*MAC_DATA_W+1 +: MAC_DATA_W] = s_data_i[r];
        end
    end

    always_comb begin
        w_head_last = w_head_word[0];
        for (int unsigned r = 0; r < ROWS; r++) begin
            w_head_data[r] = w_head_word[r*MAC_DATA_W+1 +: MAC_DATA_W];
        end
    end

    feeder_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .push_i   (s_valid_i),
        .pop_i    (w_pop),
        .wdata_i  (w_push_word),
        .rdata_o  (w_head_word),
        .full_o   (w_full),
        .empty_o  (w_empty),
        .count_o  (w_count)
    );

    assign s_ready_o   = !w_full;
    assign busy_o      = (r_state != FEEDER_IDLE) || (w_count != '0);
    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign flush_o     = r_flush;
    assign tile_done_o = r_done;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_data_nxt      = r_data;
        w_valid_nxt     = r_valid;
        w_flush_nxt     = r_flush;
        w_done_nxt      = 1'b0;
        w_pop           = 1'b0;
        if (!stall_i) begin
            case (r_state)
                FEEDER_IDLE, FEEDER_STREAM: begin
                    w_flush_nxt = 1'b0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_data_nxt  = w_head_data;
                        w_valid_nxt = 1'b1;
                        if (w_head_last) begin
                            w_state_nxt     = FEEDER_FLUSH;
                            w_flush_cnt_nxt = CNT_W'(FLUSH_CYCLES);
                        end else begin
                            w_state_nxt = FEEDER_STREAM;
                        end
                    end else begin
                        // Bubble: an empty FIFO mid-tile keeps STREAM.
                        w_data_nxt  = '{default: '0};
                        w_valid_nxt = 1'b0;
                    end
                end
                FEEDER_FLUSH: begin
                    w_data_nxt      = '{default: '0};
                    w_valid_nxt     = 1'b0;
                    w_flush_nxt     = 1'b1;
                    w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
                    if (r_flush_cnt == CNT_W'(1)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = FEEDER_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = FEEDER_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state     <= FEEDER_IDLE;
            r_flush_cnt <= '0;
            r_data      <= '{default: '0};
            r_valid     <= 1'b0;
            r_flush     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_flush     <= w_flush_nxt;
            r_done      <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_row_feeder
//   Directed bench for systolic_row_feeder (ROWS=4, FIFO_DEPTH=4,
//   FLUSH_CYCLES=7). Vectors are written as 32-bit words {e0,e1,e2,e3}.
// ---------------------------------------------------------------------------
module tb_systolic_row_feeder;
    import systolic_pkg::*;

    localparam int unsigned ROWS = 4;

    logic      clock_i = 1'b0;
    logic      resetn_i;
    t_mac_data s_data_i [ROWS];
    logic      s_valid_i;
    logic      s_last_i;
    logic      s_ready_o;
    logic      stall_i;
    t_mac_data data_o [ROWS];
    logic      valid_o;
    logic      flush_o;
    logic      tile_done_o;
    logic      busy_o;

    systolic_row_feeder #(
        .ROWS         (4),
        .FIFO_DEPTH   (4),
        .FLUSH_CYCLES (7)
    ) dut (
        .clock_i     (clock_i),
        .resetn_i    (resetn_i),
        .s_data_i    (s_data_i),
        .s_valid_i   (s_valid_i),
        .s_last_i    (s_last_i),
        .s_ready_o   (s_ready_o),
        .stall_i     (stall_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .flush_o     (flush_o),
        .tile_done_o (tile_done_o),
        .busy_o      (busy_o)
    );

    always #5 clock_i = ~clock_i;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        st;
        logic [31:0] ed;
        logic        ev;
        logic        ef;
        logic        et;
        logic        er;
        logic        eb;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic v, logic [31:0] d, logic l, logic st,
                                logic [31:0] ed, logic ev, logic ef, logic et,
                                logic er, logic eb);
        vec_t x;
        x.v = v; x.d = d; x.l = l; x.st = st;
        x.ed = ed; x.ev = ev; x.ef = ef; x.et = et; x.er = er; x.eb = eb;
        tbl.push_back(x);
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] pack_out();
        return {data_o[0], data_o[1], data_o[2], data_o[3]};
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic st);
        s_valid_i   = v;
        s_data_i[0] = d[31:24];
        s_data_i[1] = d[23:16];
        s_data_i[2] = d[15:8];
        s_data_i[3] = d[7:0];
        s_last_i    = l;
        stall_i     = st;
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_all(string tag, logic [31:0] ed, logic ev, logic ef,
                             logic et, logic er, logic eb);
        chk({tag, " data"},  pack_out(),  ed);
        chk({tag, " valid"}, valid_o,     ev);
        chk({tag, " flush"}, flush_o,     ef);
        chk({tag, " done"},  tile_done_o, et);
        chk({tag, " ready"}, s_ready_o,   er);
        chk({tag, " busy"},  busy_o,      eb);
    endtask

    // Optionally pushes a 1-vector tile on the first cycle, then runs until
    // the feeder goes idle; counts issued vectors on unstalled edges only.
    task automatic run_tile(input string tag, input bit do_push, input logic [31:0] d,
                            input bit toggle, output int nv, output int nf,
                            output int nd, output int first_v);
        int  cyc;
        logic st;
        nv = 0; nf = 0; nd = 0; first_v = -1; cyc = 0;
        while (cyc < 60) begin
            st = toggle ? logic'(cyc % 2) : 1'b0;
            drive(do_push && cyc == 0, d, do_push && cyc == 0, st);
            tick();
            nd += int'(tile_done_o);
            if (st) begin
                chk({tag, " done while stalled"}, tile_done_o, 1'b0);
            end else begin
                if (valid_o) begin
                    nv++;
                    if (first_v < 0) first_v = cyc;
                    chk({tag, " vec data"}, pack_out(), d);
                end
                if (flush_o) begin
                    nf++;
                    chk({tag, " flush data"}, pack_out(), 32'h0);
                end
            end
            cyc++;
            if (!busy_o) break;
        end
        chk({tag, " timeout"}, 32'(cyc < 60), 32'd1);
    endtask

    initial begin
        int nv, nf, nd, fv;

        // ---- reset state ----
        resetn_i = 1'b0;
        drive(0, 32'h0, 0, 0);
        #12;
        check_all("reset", 32'h0, 0, 0, 0, 1, 0);
        resetn_i = 1'b1;

        // ---- tile of 3 vectors, then 7 flush vectors ----
        add(1, 32'h01020304, 0, 0, 32'h0,        0, 0, 0, 1, 1);
        add(1, 32'h05060708, 0, 0, 32'h01020304, 1, 0, 0, 1, 1);
        add(1, 32'h090a0b0c, 1, 0, 32'h05060708, 1, 0, 0, 1, 1);
        add(0, 32'h0,        0, 0, 32'h090a0b0c, 1, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) add(0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 1, 1);
        add(0, 32'h0,        0, 0, 32'h0,        0, 1, 1, 1, 0);
        add(0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 1, 0); // last without valid
        // ---- vector, 2-cycle gap, last vector: valid 1,0,0,1 ----
        add(1, 32'h11111111, 0, 0, 32'h0,        0, 0, 0, 1, 1);
        add(0, 32'h0,        0, 0, 32'h11111111, 1, 0, 0, 1, 1);
        add(0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 1, 1);
        add(1, 32'h22222222, 1, 0, 32'h0,        0, 0, 0, 1, 1);
        add(0, 32'h0,        0, 0, 32'h22222222, 1, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) add(0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 1, 1);
        add(0, 32'h0,        0, 0, 32'h0,        0, 1, 1, 1, 0);
        add(0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].st);
            tick();
            check_all($sformatf("row%0d", i), tbl[i].ed, tbl[i].ev, tbl[i].ef,
                      tbl[i].et, tbl[i].er, tbl[i].eb);
        end

        // ---- stalled FIFO fill, 6 vectors, then release ----
        begin
            logic [31:0] v2 [6];
            int   pushed, got, cyc;
            bit   hs, done_seen;
            logic st;
            for (int k = 0; k < 6; k++) v2[k] = 32'h30313233 + 32'h01010101 * k;
            pushed = 0; got = 0; cyc = 0; done_seen = 0;
            while (cyc < 60 && !done_seen) begin
                st = (cyc < 6);
                hs = (pushed < 6) && s_ready_o;
                drive(pushed < 6, (pushed < 6) ? v2[pushed] : 32'h0, pushed == 5, st);
                tick();
                if (hs) pushed++;
                if (cyc == 3) begin
                    chk("fill ready low", s_ready_o, 1'b0);
                    chk("fill accepted", pushed, 4);
                end
                if (st) begin
                    chk("stall valid frozen", valid_o, 1'b0);
                    chk("stall data frozen", pack_out(), 32'h0);
                end else if (valid_o) begin
                    chk($sformatf("fill out%0d", got), pack_out(), (got < 6) ? v2[got] : 32'hdeadbeef);
                    got++;
                end
                if (tile_done_o) done_seen = 1;
                cyc++;
            end
            chk("fill pushed", pushed, 6);
            chk("fill emitted", got, 6);
            chk("fill done", done_seen, 1'b1);
            tick();
            chk("fill idle", busy_o, 1'b0);
        end

        // ---- back-to-back tiles A(2) and B(1), stall mid-FLUSH ----
        drive(1, 32'h41424344, 0, 0); tick();
        check_all("bb a0 push", 32'h0, 0, 0, 0, 1, 1);
        drive(1, 32'h45464748, 1, 0); tick();
        check_all("bb a0 out", 32'h41424344, 1, 0, 0, 1, 1);
        drive(1, 32'h51525354, 1, 0); tick();
        check_all("bb a1 out", 32'h45464748, 1, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            drive(0, 32'h0, 0, (i >= 3 && i < 6));
            tick();
            check_all($sformatf("bb flush%0d", i), 32'h0, 0, 1, (i == 9), 1, 1);
        end
        drive(0, 32'h0, 0, 0); tick();
        check_all("bb b0 out", 32'h51525354, 1, 0, 0, 1, 1);
        run_tile("bb drain", 0, 32'h51525354, 0, nv, nf, nd, fv);
        chk("bb drain valid", nv, 0);
        chk("bb drain flush", nf, 7);
        chk("bb drain done", nd, 1);

        // ---- asynchronous reset mid-STREAM ----
        drive(1, 32'h61616161, 0, 0); tick();
        drive(1, 32'h62626262, 0, 0); tick();
        drive(1, 32'h63636363, 0, 0); tick();
        check_all("pre reset", 32'h62626262, 1, 0, 0, 1, 1);
        drive(0, 32'h0, 0, 0);
        #3 resetn_i = 1'b0;
        #1;
        check_all("async reset", 32'h0, 0, 0, 0, 1, 0);
        #2 resetn_i = 1'b1;
        run_tile("post reset", 1, 32'h71727374, 0, nv, nf, nd, fv);
        chk("post reset valid", nv, 1);
        chk("post reset latency", fv, 1);
        chk("post reset flush", nf, 7);
        chk("post reset done", nd, 1);

        // ---- 1-vector tile with stall toggling every cycle ----
        run_tile("toggle", 1, 32'h7f808182, 1, nv, nf, nd, fv);
        chk("toggle valid", nv, 1);
        chk("toggle flush", nf, 7);
        chk("toggle done", nd, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
